lfsr_step_unit: RTL and testbench
=================================

Name: lfsr_step_unit

Overview:
- Multi-cycle LFSR execution unit for the 8-bit LFSR datapath; sits directly upstream of the register file.
- Consumes seed/tap/step-count operands read from the register file and advances a Fibonacci LFSR N steps.
- Produces a one-cycle write-back request (write enable, write address, write data) plus a parity flag that drive the register file's write port and parity input.

Parameters:
W, 8, data path width (seed, taps, step count, result)
D, 3, register address width (write-back destination)

Ports:
Clk      in   1   clock, rising edge
Reset    in   1   asynchronous, active-low reset (unit is in reset while Reset==0)
Start    in   1   launch request; sampled only in IDLE
Abort    in   1   synchronous cancel of an in-flight operation
Seed     in   W   initial LFSR state
Taps     in   W   feedback tap mask
Steps    in   W   number of LFSR steps, 0..2**W-1
DstAddr  in   D   write-back register address
Busy     out  1   high in RUN and WB
Done     out  1   one-cycle pulse, coincident with WriteEn
WriteEn  out  1   register-file write strobe, one cycle
Waddr    out  D   write-back address; latched DstAddr
DataOut  out  W   LFSR result; register-file write data
ParityFlg out 1   XOR-reduce of DataOut, registered

Behaviour:
- Step function: fb = ^(state & Taps_latched); next = {state[W-2:0], fb}. Taps==0 gives a pure left shift with 0 fill. Seed==0 stays 0.
- Reset (async, Reset==0): state=IDLE, lfsr reg=0, counter=0, Waddr=0, WriteEn=0, Done=0, Busy=0, ParityFlg=0, DataOut=0. Deassertion takes effect at the next Clk edge.
- FSM states: IDLE, RUN, WB.
- IDLE:
  - Start==1 latches Seed, Taps, Steps and DstAddr.
  - Steps==0 -> WB; otherwise -> RUN with counter=Steps.
  - Start==0 -> stay in IDLE.
- RUN:
  - Each cycle: lfsr <= next(lfsr), counter <= counter-1.
  - When counter==1 at the edge -> WB.
  - RUN therefore lasts exactly Steps cycles.
- WB:
  - WriteEn=1 and Done=1 for exactly this one cycle.
  - DataOut = final lfsr value; Waddr = latched DstAddr.
  - ParityFlg updates to ^final value on entry to WB.
  - -> IDLE unconditionally.
- Latency: Start sampled at edge k gives WriteEn high during the cycle after edge k+Steps+1, i.e. Steps+1 cycles after launch; Steps==0 gives 1 cycle.
- Outputs outside WB:
  - WriteEn=0 and Done=0.
  - DataOut and ParityFlg hold their last result until the next WB.
  - Waddr holds its last value.
- Start while Busy: ignored, no queuing. Operand inputs are don't-care after the launch edge.
- Abort:
  - In RUN or WB: -> IDLE at the next edge, no WriteEn pulse, DataOut/ParityFlg not updated. Abort in the WB cycle suppresses nothing already asserted that cycle; WriteEn still pulses once in WB.
  - In IDLE, Abort has priority over Start: Start is dropped.
- Reset mid-operation: immediate return to reset values; no write-back is issued.
- Counter is W bits wide; Steps=2**W-1 must complete without wrap.
- Back-to-back: a new Start may be sampled in the IDLE cycle following WB, so there is a minimum 1 idle cycle between write-backs.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Decomposition:
- Shared package lfsr_pkg:
  - state enum (IDLE, RUN, WB), 2-bit encoding.
  - default W=8, D=3 constants.
  - standard tap constant TAPS_X8654 = 8'hB8.
- Sub-module lfsr_next:
  - combinational one-step function (state, taps -> next state).
  - instantiated once; reusable by other LFSR stages.

Test Plan:
- Seed=0x01, Taps=0xB8, Steps=1, DstAddr=3 -> WriteEn pulse 2 cycles after Start edge; Waddr=3, DataOut=0x02, ParityFlg=1.
- Seed=0x01, Taps=0xB8, Steps=8, DstAddr=5 -> Busy high 9 cycles; one WriteEn/Done pulse; DataOut=0x1C, ParityFlg=1. Intermediate step-4 run (Steps=4) -> DataOut=0x11, ParityFlg=0.
- Seed=0x5A, Steps=0, DstAddr=6 -> WriteEn one cycle after Start; DataOut=0x5A, ParityFlg=0. Start re-asserted during Busy -> ignored, exactly one write.
- Steps=8 launch; Abort at 4th RUN cycle -> IDLE next edge, no WriteEn, DataOut keeps previous value 0x5A.
- Steps=8 launch; Reset driven 0 mid-RUN, asynchronous between edges -> all outputs 0 immediately; after release, IDLE; new Start (Seed=0x01, Steps=4) -> DataOut=0x11.
- Seed=0x00, Taps=0xFF, Steps=255 -> completes after 255 RUN cycles (no counter wrap); DataOut=0x00, ParityFlg=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR datapath: widths, FSM encoding, standard taps.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned LFSR_D = 3;

    // x^8 + x^6 + x^5 + x^4 + 1, maximal-length for 8 bits
    localparam logic [7:0] TAPS_X8654 = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_step_unit_next.sv
// One Fibonacci LFSR step: shift left, feedback is the parity of the tapped bits.
module lfsr_next #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] state,
    input  logic [W-1:0] taps,
    output logic [W-1:0] nxt_c
);

    assign nxt_c = {state[W-2:0], ^(state & taps)};

endmodule

// File: rtl/lfsr_step_unit.sv
// Multi-cycle LFSR execution unit: advances a latched seed N steps and issues a
// single-cycle register-file write-back of the result with its parity.
module lfsr_step_unit
    import lfsr_pkg::*;
#(
    parameter int unsigned W = LFSR_W,
    parameter int unsigned D = LFSR_D
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic [W-1:0] Seed,
    input  logic [W-1:0] Taps,
    input  logic [W-1:0] Steps,
    input  logic [D-1:0] DstAddr,
    output logic         Busy,
    output logic         Done,
    output logic         WriteEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataOut,
    output logic         ParityFlg
);

    state_e       state_q,  state_d;
    logic [W-1:0] lfsr_q,   lfsr_d;
    logic [W-1:0] taps_q,   taps_d;
    logic [W-1:0] cnt_q,    cnt_d;
    logic [D-1:0] dst_q,    dst_d;
    logic [D-1:0] waddr_q,  waddr_d;
    logic [W-1:0] data_q,   data_d;
    logic         par_q,    par_d;
    logic         we_q,     we_d;
    logic         busy_q,   busy_d;
    logic [W-1:0] lfsr_nxt_c;

    lfsr_next #(.W(W)) u_next (
        .state (lfsr_q),
        .taps  (taps_q),
        .nxt_c (lfsr_nxt_c)
    );

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            taps_q  <= '0;
            cnt_q   <= '0;
            dst_q   <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            par_q   <= par_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output decode; result registers load only on entry to WB
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        taps_d  = taps_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        par_d   = par_q;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    lfsr_d = Seed;
                    taps_d = Taps;
                    dst_d  = DstAddr;
                    cnt_d  = Steps;
                    if (Steps == '0) begin
                        state_d = WB;
                        data_d  = Seed;
                        par_d   = ^Seed;
                        waddr_d = DstAddr;
                        we_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (Abort) begin
                    state_d = IDLE;
                end else begin
                    lfsr_d = lfsr_nxt_c;
                    cnt_d  = cnt_q - W'(1);
                    if (cnt_q == W'(1)) begin
                        state_d = WB;
                        data_d  = lfsr_nxt_c;
                        par_d   = ^lfsr_nxt_c;
                        waddr_d = dst_q;
                        we_d    = 1'b1;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign Busy      = busy_q;
    assign Done      = we_q;
    assign WriteEn   = we_q;
    assign Waddr     = waddr_q;
    assign DataOut   = data_q;
    assign ParityFlg = par_q;

endmodule

// File: tb/tb_lfsr_step_unit.sv
// Directed bench for lfsr_step_unit: vector table plus abort/reset sequences.
module tb_lfsr_step_unit;
    import lfsr_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [7:0] Seed = '0;
    logic [7:0] Taps = '0;
    logic [7:0] Steps = '0;
    logic [2:0] DstAddr = '0;
    logic       Busy, Done, WriteEn, ParityFlg;
    logic [2:0] Waddr;
    logic [7:0] DataOut;

    int tests = 0;
    int fails = 0;

    lfsr_step_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Seed(Seed), .Taps(Taps), .Steps(Steps), .DstAddr(DstAddr),
        .Busy(Busy), .Done(Done), .WriteEn(WriteEn), .Waddr(Waddr),
        .DataOut(DataOut), .ParityFlg(ParityFlg)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [7:0] seed;
        logic [7:0] taps;
        logic [7:0] steps;
        logic [2:0] dst;
        logic [7:0] exp_data;
        logic       exp_par;
        bit         restart;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Busy"},      32'(Busy),      0);
        chk({tag, " Done"},      32'(Done),      0);
        chk({tag, " WriteEn"},   32'(WriteEn),   0);
        chk({tag, " Waddr"},     32'(Waddr),     0);
        chk({tag, " DataOut"},   32'(DataOut),   0);
        chk({tag, " ParityFlg"}, 32'(ParityFlg), 0);
    endtask

    // Launch one operation and watch it through write-back and the idle cycle after
    task automatic run_op(input vec_t v);
        int n, lat, pulses, busy_cnt, done_bad;
        n = int'(v.steps);
        lat = -1; pulses = 0; busy_cnt = 0; done_bad = 0;
        @(negedge Clk);
        Seed = v.seed; Taps = v.taps; Steps = v.steps; DstAddr = v.dst; Start = 1'b1;
        for (int cyc = 1; cyc <= n + 2; cyc++) begin
            @(negedge Clk);
            if (v.restart && cyc <= n + 1) begin
                Start = 1'b1; Seed = 8'hFF; Taps = 8'hFF; Steps = 8'd3; DstAddr = 3'd0;
            end else begin
                Start = 1'b0;
            end
            if (Busy) busy_cnt++;
            if (Done !== WriteEn) done_bad++;
            if (WriteEn) begin
                pulses++;
                lat = cyc;
                chk({v.name, " DataOut"},   32'(DataOut),   32'(v.exp_data));
                chk({v.name, " ParityFlg"}, 32'(ParityFlg), 32'(v.exp_par));
                chk({v.name, " Waddr"},     32'(Waddr),     32'(v.dst));
            end
        end
        chk({v.name, " pulses"},    32'(pulses),   1);
        chk({v.name, " latency"},   32'(lat),      32'(n + 1));
        chk({v.name, " busy_cyc"},  32'(busy_cnt), 32'(n + 1));
        chk({v.name, " done_eq"},   32'(done_bad), 0);
        chk({v.name, " idle_busy"}, 32'(Busy),     0);
        chk({v.name, " hold_data"}, 32'(DataOut),  32'(v.exp_data));
    endtask

    initial begin
        int we_seen;
        vec_t v;

        vecs[0] = '{"shift0",  8'h81, 8'h00,       8'd3,   3'd1, 8'h08, 1'b1, 1'b0};
        vecs[1] = '{"max255",  8'h00, 8'hFF,       8'd255, 3'd7, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{"step1",   8'h01, TAPS_X8654,  8'd1,   3'd3, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{"step8",   8'h01, TAPS_X8654,  8'd8,   3'd5, 8'h1C, 1'b1, 1'b0};
        vecs[4] = '{"step4",   8'h01, TAPS_X8654,  8'd4,   3'd2, 8'h11, 1'b0, 1'b0};
        vecs[5] = '{"step0rs", 8'h5A, TAPS_X8654,  8'd0,   3'd6, 8'h5A, 1'b0, 1'b1};

        #12;
        chk_reset_vals("rst");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_rel Busy", 32'(Busy), 0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort has priority over Start in IDLE
        @(negedge Clk);
        Seed = 8'h01; Taps = TAPS_X8654; Steps = 8'd2; DstAddr = 3'd4; Start = 1'b1; Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        chk("idle_abort Busy", 32'(Busy), 0);

        // Abort on the 4th RUN cycle: no write-back, previous result held
        Start = 1'b1; Steps = 8'd8;
        we_seen = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (WriteEn) we_seen++;
        end
        chk("abort pre Busy", 32'(Busy), 1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort Busy", 32'(Busy), 0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (WriteEn) we_seen++;
            @(negedge Clk);
        end
        chk("abort WriteEn", 32'(we_seen), 0);
        chk("abort DataOut", 32'(DataOut), 32'h5A);
        chk("abort Parity",  32'(ParityFlg), 0);
        chk("abort Waddr",   32'(Waddr), 6);

        // Asynchronous reset mid-RUN
        Seed = 8'h01; Taps = TAPS_X8654; Steps = 8'd8; DstAddr = 3'd5; Start = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        chk("midrst pre Busy", 32'(Busy), 1);
        #2 Reset = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge Clk);
        Reset = 1'b1;
        we_seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge Clk);
            if (WriteEn || Busy) we_seen++;
        end
        chk("midrst idle", 32'(we_seen), 0);
        v = '{"post_rst", 8'h01, TAPS_X8654, 8'd4, 3'd2, 8'h11, 1'b0, 1'b0};
        run_op(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
